// File: rtl/lsu_arbiter_if.sv
// Bundles the two requester ports and the memory-controller load/store port
// shared by lsu_arbiter. The arbiter takes the slave side.
interface lsu_arbiter_if;
  logic        r0_req_i;
  logic [11:0] r0_addr_i;
  logic        r0_wren_i;
  logic [3:0]  r0_ls_op_i;
  logic [31:0] r0_st_data_i;
  logic        r0_gnt_o;
  logic        r0_rvalid_o;
  logic        r0_err_o;

  logic        r1_req_i;
  logic [11:0] r1_addr_i;
  logic        r1_wren_i;
  logic [3:0]  r1_ls_op_i;
  logic [31:0] r1_st_data_i;
  logic        r1_gnt_o;
  logic        r1_rvalid_o;
  logic        r1_err_o;

  logic [31:0] rdata_o;
  logic [11:0] mem_addr_o;
  logic [31:0] mem_st_data_o;
  logic        mem_wren_o;
  logic [3:0]  mem_ls_op_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  r0_req_i, r0_addr_i, r0_wren_i, r0_ls_op_i, r0_st_data_i,
    input  r1_req_i, r1_addr_i, r1_wren_i, r1_ls_op_i, r1_st_data_i,
    input  mem_rdata_i,
    output r0_gnt_o, r0_rvalid_o, r0_err_o,
    output r1_gnt_o, r1_rvalid_o, r1_err_o,
    output rdata_o, mem_addr_o, mem_st_data_o, mem_wren_o, mem_ls_op_o
  );

  modport master (
    output r0_req_i, r0_addr_i, r0_wren_i, r0_ls_op_i, r0_st_data_i,
    output r1_req_i, r1_addr_i, r1_wren_i, r1_ls_op_i, r1_st_data_i,
    output mem_rdata_i,
    input  r0_gnt_o, r0_rvalid_o, r0_err_o,
    input  r1_gnt_o, r1_rvalid_o, r1_err_o,
    input  rdata_o, mem_addr_o, mem_st_data_o, mem_wren_o, mem_ls_op_o
  );
endinterface

// File: rtl/lsu_arbiter.sv
// Shares the memory controller's single load/store port between the core LSU
// (requester 0) and the debug loader (requester 1), one transaction at a time.
module lsu_arbiter #(
  parameter bit RR = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  lsu_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]  state_q;
  logic        id_q;
  logic        wren_q;
  logic        err_q;
  logic        last_q;
  logic [11:0] addr_q;
  logic [3:0]  op_q;
  logic [31:0] sdata_q;
  logic [31:0] rdata_q;

  logic        idle;
  logic        any_req;
  logic        pick1;
  logic [11:0] sel_addr;
  logic        sel_wren;
  logic [3:0]  sel_op;
  logic [31:0] sel_sdata;
  logic        sel_err;

  // Opcode range, unmapped space, read-only input region, and the
  // out-of-window unaligned store into region 4.
  function automatic logic req_err(input logic [11:0] addr, input logic wren,
                                   input logic [3:0] op);
    logic bad;
    bad = (op == 4'd0) || (op > 4'd8);
    bad = bad || (addr[11:8] >= 4'd6);
    bad = bad || (wren && addr[11:8] == 4'd5);
    bad = bad || (wren && addr[11:8] == 4'd4 && addr > 12'h4A0 && addr[3:0] != 4'd0);
    return bad;
  endfunction

  always_comb begin
    idle    = (state_q == S_IDLE) && rst_ni;
    any_req = bus.r0_req_i || bus.r1_req_i;
    if (RR) pick1 = bus.r1_req_i && (!bus.r0_req_i || !last_q);
    else    pick1 = bus.r1_req_i && !bus.r0_req_i;

    sel_addr  = pick1 ? bus.r1_addr_i    : bus.r0_addr_i;
    sel_wren  = pick1 ? bus.r1_wren_i    : bus.r0_wren_i;
    sel_op    = pick1 ? bus.r1_ls_op_i   : bus.r0_ls_op_i;
    sel_sdata = pick1 ? bus.r1_st_data_i : bus.r0_st_data_i;
    sel_err   = req_err(sel_addr, sel_wren, sel_op);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      id_q    <= 1'b0;
      wren_q  <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      op_q    <= '0;
      sdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            id_q    <= pick1;
            addr_q  <= sel_addr;
            wren_q  <= sel_wren;
            op_q    <= sel_op;
            sdata_q <= sel_data_or(sel_sdata);
            err_q   <= sel_err;
            if (sel_err) begin
              rdata_q <= '0;
              state_q <= S_RESP;
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          rdata_q <= bus.mem_rdata_i;
          state_q <= S_RESP;
        end
        S_RESP: begin
          last_q  <= id_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  function automatic logic [31:0] sel_data_or(input logic [31:0] d);
    return d;
  endfunction

  // Store strobe only exists in ACCESS, so an async reset aborts it at once.
  always_comb begin
    bus.r0_gnt_o      = idle && any_req && !pick1;
    bus.r1_gnt_o      = idle && pick1;
    bus.r0_rvalid_o   = (state_q == S_RESP) && !id_q;
    bus.r1_rvalid_o   = (state_q == S_RESP) && id_q;
    bus.r0_err_o      = (state_q == S_RESP) && !id_q && err_q;
    bus.r1_err_o      = (state_q == S_RESP) && id_q && err_q;
    bus.rdata_o       = rdata_q;
    bus.mem_addr_o    = addr_q;
    bus.mem_st_data_o = sdata_q;
    bus.mem_ls_op_o   = op_q;
    bus.mem_wren_o    = (state_q == S_ACCESS) && wren_q;
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: directed vector table, tie/priority and reset corner
// sequences, then random traffic against a transaction-level reference model.
module tb_lsu_arbiter;

  logic clk;
  logic rst_n;

  lsu_arbiter_if bi();
  lsu_arbiter_if bf();

  lsu_arbiter #(.RR(1'b1)) u_rr (.clk_i(clk), .rst_ni(rst_n), .bus(bi));
  lsu_arbiter #(.RR(1'b0)) u_fp (.clk_i(clk), .rst_ni(rst_n), .bus(bf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit        id;
    bit [11:0] addr;
    bit        wren;
    bit [3:0]  op;
    bit [31:0] sd;
    bit [31:0] mrd;
    bit        exp_err;
    bit [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  // Reference rules for rejection, stated on the plain address value.
  function automatic bit model_err(input bit [11:0] a, input bit w, input bit [3:0] op);
    if (op == 0 || op > 8) return 1'b1;
    if (a >= 12'h600) return 1'b1;
    if (w && a >= 12'h500) return 1'b1;
    if (w && a >= 12'h400 && a > 12'h4A0 && (a % 16) != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_req(input bit id, input bit req, input bit [11:0] a, input bit w,
                           input bit [3:0] op, input bit [31:0] sd);
    if (id) begin
      bi.r1_req_i = req; bi.r1_addr_i = a; bi.r1_wren_i = w;
      bi.r1_ls_op_i = op; bi.r1_st_data_i = sd;
    end else begin
      bi.r0_req_i = req; bi.r0_addr_i = a; bi.r0_wren_i = w;
      bi.r0_ls_op_i = op; bi.r0_st_data_i = sd;
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive_req(v.id, 1'b1, v.addr, v.wren, v.op, v.sd);
    drive_req(!v.id, 1'b0, 12'h0, 1'b0, 4'd0, 32'h0);
    #1;
    chk("vec_gnt", v.id ? bi.r1_gnt_o : bi.r0_gnt_o, 1);
    chk("vec_gnt_other", v.id ? bi.r0_gnt_o : bi.r1_gnt_o, 0);
    @(negedge clk);
    drive_req(v.id, 1'b0, v.addr, v.wren, v.op, v.sd);
    bi.mem_rdata_i = v.mrd;
    #1;
    if (v.exp_err) begin
      chk("err_rvalid", v.id ? bi.r1_rvalid_o : bi.r0_rvalid_o, 1);
      chk("err_err", v.id ? bi.r1_err_o : bi.r0_err_o, 1);
      chk("err_rdata", bi.rdata_o, 0);
      chk("err_wren", bi.mem_wren_o, 0);
    end else begin
      chk("acc_wren", bi.mem_wren_o, v.wren);
      chk("acc_addr", bi.mem_addr_o, v.addr);
      chk("acc_op", bi.mem_ls_op_o, v.op);
      if (v.wren) chk("acc_sdata", bi.mem_st_data_o, v.sd);
      chk("acc_rvalid", {bi.r1_rvalid_o, bi.r0_rvalid_o}, 0);
      @(negedge clk);
      bi.mem_rdata_i = $urandom;
      #1;
      chk("resp_rvalid", v.id ? bi.r1_rvalid_o : bi.r0_rvalid_o, 1);
      chk("resp_err", v.id ? bi.r1_err_o : bi.r0_err_o, 0);
      chk("resp_rdata", bi.rdata_o, v.exp_rdata);
      chk("resp_wren", bi.mem_wren_o, 0);
    end
  endtask

  initial begin
    int ng;
    int gid[4];
    int gcyc[4];
    int fp0, fp1;
    bit        pend[2];
    bit [11:0] p_addr[2];
    bit        p_wren[2];
    bit [3:0]  p_op[2];
    bit [31:0] p_sd[2];
    int  free_at, t_start;
    bit  have, m_last, t_id, t_err, t_wren, w, e;
    bit [11:0] t_addr;
    bit [3:0]  t_op;
    bit [31:0] t_sd, t_rdata;
    bit [1:0]  e_gnt, e_rv, e_er;

    rst_n = 1'b0;
    drive_req(1'b0, 1'b0, 12'h0, 1'b0, 4'd0, 32'h0);
    drive_req(1'b1, 1'b0, 12'h0, 1'b0, 4'd0, 32'h0);
    bi.mem_rdata_i = 32'h0;
    bf.r0_req_i = 1'b0; bf.r0_addr_i = 12'h010; bf.r0_wren_i = 1'b0;
    bf.r0_ls_op_i = 4'd6; bf.r0_st_data_i = 32'h0;
    bf.r1_req_i = 1'b0; bf.r1_addr_i = 12'h020; bf.r1_wren_i = 1'b0;
    bf.r1_ls_op_i = 4'd6; bf.r1_st_data_i = 32'h0;
    bf.mem_rdata_i = 32'h0;

    vecs[0] = '{1'b0, 12'h010, 1'b0, 4'd6, 32'h0,        32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 12'h400, 1'b1, 4'd3, 32'h12345678, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5};
    vecs[2] = '{1'b0, 12'h600, 1'b0, 4'd4, 32'h0,        32'h11111111, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 12'h500, 1'b1, 4'd3, 32'hCAFEF00D, 32'h22222222, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 12'h020, 1'b0, 4'd9, 32'h0,        32'h33333333, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 12'h030, 1'b0, 4'd0, 32'h0,        32'h44444444, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 12'h4B4, 1'b1, 4'd1, 32'h000000AB, 32'h55555555, 1'b1, 32'h0};
    vecs[7] = '{1'b0, 12'h4B0, 1'b1, 4'd2, 32'h0000BEEF, 32'h66666666, 1'b0, 32'h66666666};
    vecs[8] = '{1'b1, 12'h5FF, 1'b0, 4'd7, 32'h0,        32'h77777777, 1'b0, 32'h77777777};
    vecs[9] = '{1'b0, 12'h4A0, 1'b1, 4'd3, 32'h01020304, 32'h88888888, 1'b0, 32'h88888888};

    // Reset values
    #3;
    chk("rst_gnt", {bi.r1_gnt_o, bi.r0_gnt_o}, 0);
    chk("rst_rvalid", {bi.r1_rvalid_o, bi.r0_rvalid_o}, 0);
    chk("rst_err", {bi.r1_err_o, bi.r0_err_o}, 0);
    chk("rst_wren", bi.mem_wren_o, 0);
    chk("rst_addr", bi.mem_addr_o, 0);
    chk("rst_sdata", bi.mem_st_data_o, 0);
    chk("rst_op", bi.mem_ls_op_o, 0);
    chk("rst_rdata", bi.rdata_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin tie: both held for four transactions
    @(negedge clk);
    drive_req(1'b0, 1'b1, 12'h010, 1'b0, 4'd6, 32'h0);
    drive_req(1'b1, 1'b1, 12'h020, 1'b0, 4'd6, 32'h0);
    bf.r0_req_i = 1'b1; bf.r1_req_i = 1'b1;
    ng = 0; fp0 = 0; fp1 = 0;
    for (int c = 0; c < 20 && ng < 4; c++) begin
      #1;
      chk("rr_both_gnt", bi.r0_gnt_o & bi.r1_gnt_o, 0);
      if (bi.r0_gnt_o || bi.r1_gnt_o) begin
        gid[ng] = bi.r1_gnt_o; gcyc[ng] = c; ng++;
      end
      if (c < 12) begin
        fp0 += int'(bf.r0_gnt_o);
        fp1 += int'(bf.r1_gnt_o);
      end
      @(negedge clk);
    end
    chk("rr_count", ng, 4);
    for (int i = 0; i < ng; i++) chk("rr_order", gid[i], i % 2);
    for (int i = 1; i < ng; i++) chk("rr_gap", gcyc[i] - gcyc[i-1], 3);
    chk("fp_r0_grants", fp0, 4);
    chk("fp_r1_starved", fp1, 0);
    drive_req(1'b0, 1'b0, 12'h0, 1'b0, 4'd0, 32'h0);
    drive_req(1'b1, 1'b0, 12'h0, 1'b0, 4'd0, 32'h0);
    bf.r0_req_i = 1'b0; bf.r1_req_i = 1'b0;
    repeat (3) @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset during the ACCESS cycle of an r1 byte store
    @(negedge clk);
    drive_req(1'b1, 1'b1, 12'h410, 1'b1, 4'd1, 32'h000000FF);
    #1;
    chk("rst_mid_gnt", bi.r1_gnt_o, 1);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 12'h410, 1'b1, 4'd1, 32'h000000FF);
    #1;
    chk("rst_mid_wren_hi", bi.mem_wren_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wren_lo", bi.mem_wren_o, 0);
    chk("rst_mid_rvalid", {bi.r1_rvalid_o, bi.r0_rvalid_o}, 0);
    chk("rst_mid_addr", bi.mem_addr_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_no_rvalid", {bi.r1_rvalid_o, bi.r0_rvalid_o}, 0);
    @(negedge clk);
    drive_req(1'b0, 1'b1, 12'h010, 1'b0, 4'd6, 32'h0);
    drive_req(1'b1, 1'b1, 12'h020, 1'b0, 4'd6, 32'h0);
    #1;
    chk("rst_mid_tie_r0", {bi.r1_gnt_o, bi.r0_gnt_o}, 2'b01);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 12'h0, 1'b0, 4'd0, 32'h0);
    drive_req(1'b1, 1'b0, 12'h0, 1'b0, 4'd0, 32'h0);

    // Random traffic against the transaction model (fresh reset first)
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pend[0] = 0; pend[1] = 0;
    free_at = 0; have = 0; m_last = 1; t_start = 0;
    t_id = 0; t_err = 0; t_wren = 0; t_addr = 0; t_op = 0; t_sd = 0; t_rdata = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom % 3) == 0) begin
          pend[p] = 1;
          p_addr[p] = (($urandom % 4) == 0) ? 12'(12'h400 + $urandom_range(0, 255))
                                            : 12'($urandom_range(0, 4095));
          p_wren[p] = 1'($urandom);
          p_op[p] = 4'($urandom_range(0, 9));
          p_sd[p] = $urandom;
        end else if (pend[p] && ($urandom % 16) == 0) begin
          pend[p] = 0;
        end
        drive_req(p[0], pend[p], p_addr[p], p_wren[p], p_op[p], p_sd[p]);
      end
      bi.mem_rdata_i = $urandom;
      #1;
      e_gnt = 2'b00;
      if (cyc >= free_at && (pend[0] || pend[1])) begin
        w = pend[1] && (!pend[0] || m_last == 0);
        e = model_err(p_addr[w], p_wren[w], p_op[w]);
        have = 1; t_start = cyc; t_id = w; t_err = e;
        t_addr = p_addr[w]; t_wren = p_wren[w]; t_op = p_op[w]; t_sd = p_sd[w];
        free_at = cyc + (e ? 2 : 3);
        e_gnt[w] = 1'b1;
      end
      chk("rnd_gnt", {bi.r1_gnt_o, bi.r0_gnt_o}, e_gnt);
      if (have && !t_err && cyc == t_start + 1) begin
        chk("rnd_wren", bi.mem_wren_o, t_wren);
        chk("rnd_addr", bi.mem_addr_o, t_addr);
        chk("rnd_op", bi.mem_ls_op_o, t_op);
        chk("rnd_sdata", bi.mem_st_data_o, t_sd);
        t_rdata = bi.mem_rdata_i;
      end else begin
        chk("rnd_wren_idle", bi.mem_wren_o, 0);
      end
      e_rv = 2'b00; e_er = 2'b00;
      if (have && cyc == t_start + (t_err ? 1 : 2)) begin
        e_rv[t_id] = 1'b1;
        e_er[t_id] = t_err;
        chk("rnd_rdata", bi.rdata_o, t_err ? 32'h0 : t_rdata);
        m_last = t_id;
        have = 0;
      end
      chk("rnd_rvalid", {bi.r1_rvalid_o, bi.r0_rvalid_o}, e_rv);
      chk("rnd_err", {bi.r1_err_o, bi.r0_err_o}, e_er);
      if (e_gnt[0]) pend[0] = 0;
      if (e_gnt[1]) pend[1] = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_arbiter.md
# lsu_arbiter

Two-port arbiter that shares the single load/store port of the memory controller between the core load/store stage (requester 0) and the debug/program-loader port (requester 1). It accepts one request at a time through a request/grant handshake, drives the memory controller's address, store data, write-enable and load/store opcode from registered copies for exactly one cycle, and returns load data or store completion with a one-cycle valid pulse. Malformed requests are rejected without touching memory.

## Interface
- RR, 1: 1 = round-robin between requesters; 0 = fixed priority, requester 0 always wins.
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- rN_req_i  in  1  request from requester N (N = 0,1); held until granted.
- rN_addr_i  in  12  byte address.
- rN_wren_i  in  1  1 = store, 0 = load.
- rN_ls_op_i  in  4  opcode: SB=1, SH=2, SW=3, LB=4, LH=5, LW=6, LBU=7, LHU=8.
- rN_st_data_i  in  32  store data.
- rN_gnt_o  out  1  request accepted this cycle.
- rN_rvalid_o  out  1  one-cycle completion pulse for requester N.
- rN_err_o  out  1  qualifies rN_rvalid_o; 1 = request rejected.
- rdata_o  out  32  response data, shared by both requesters; meaningful only with an rvalid pulse.
- mem_addr_o  out  12  to the memory controller.
- mem_st_data_o  out  32  to the memory controller.
- mem_wren_o  out  1  to the memory controller.
- mem_ls_op_o  out  4  to the memory controller.
- mem_rdata_i  in  32  combinational load data from the memory controller.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any rN_req_i is high, pick a winner.
    - RR=1: the requester not granted last wins a tie; the last-grant register resets to 1, so requester 0 wins the first tie.
    - RR=0: requester 0 always wins.
  - Assert the winner's gnt_o combinationally.
  - Capture the winner's addr, wren, ls_op and st_data, plus the winner id.
  - Evaluate the error condition, then go to ACCESS, or to RESP if the error condition is true.
- Error condition, any of:
  - ls_op is 0 or greater than 8.
  - addr[11:8] is 6 or higher.
  - A store to addr[11:8] = 5 (input region is read-only).
  - A store with addr[11:8] = 4 and addr outside 0x400..0x4A0 with addr[3:0] ≠ 0.
- ACCESS (one cycle):
  - mem_* outputs come from the captured registers, with mem_wren_o equal to the captured wren.
  - mem_rdata_i is registered into rdata_o at the end of the cycle.
  - Next state is RESP.
- RESP (one cycle):
  - Winner's rvalid_o = 1; err_o = 1 only for a rejected request.
  - rdata_o = 0 on error; otherwise the value captured in ACCESS. Stores return that value too, and it is not checked.
  - Update the last-grant register, then go to IDLE.
- mem_wren_o is 0 in every state except ACCESS. mem_addr_o, mem_st_data_o and mem_ls_op_o hold their last captured values outside ACCESS.
- No request is granted outside IDLE. A requester that drops req_i before grant is simply not served.

## Timing
- Request sampled in cycle N (IDLE): gnt_o in N, memory access in N+1, rvalid_o in N+2, next grant possible in N+3. Throughput is one transaction per 3 cycles.
- Rejected request: gnt in N, rvalid_o with err_o in N+1 (ACCESS is skipped, no memory access), next grant in N+2.
- SB/SH: the memory controller merges internally within the single ACCESS cycle. The arbiter holds addr and ls_op stable for the whole ACCESS cycle.
- Reset values:
  - State = IDLE.
  - All gnt_o, rvalid_o and err_o = 0.
  - mem_wren_o = 0.
  - mem_addr_o, mem_st_data_o, mem_ls_op_o and rdata_o = 0.
  - Last-grant = 1.
- Reset asserted mid-transaction:
  - All outputs take their reset values immediately (asynchronously). mem_wren_o falls within the same cycle, so the store is aborted.
  - No rvalid is issued for the in-flight request.
- Simultaneous requests while busy: both wait. Arbitration happens on the first IDLE cycle.

## Test plan
- Reset, then r0 LW at 0x010 with mem_rdata_i = 0xDEADBEEF: r0_gnt_o in N, mem_wren_o = 0 and mem_addr_o = 0x010 in N+1, r0_rvalid_o = 1 with rdata_o = 0xDEADBEEF in N+2.
- r1 SW 0x12345678 at 0x400: mem_wren_o = 1 for exactly one cycle with mem_st_data_o = 0x12345678 and mem_ls_op_o = 3; r1_rvalid_o = 1 and r1_err_o = 0 two cycles after grant.
- Both requesters held high for 4 transactions with RR=1: grants go r0, r1, r0, r1, each 3 cycles apart. With RR=0: r0 granted every time and r1 starves.
- Error cases:
  - r0 load at 0x600: r0_rvalid_o and r0_err_o pulse the cycle after grant, rdata_o = 0, mem_wren_o never rises.
  - r1 SW at 0x500: rejected the same way.
  - ls_op = 9: rejected the same way.
- r1 SB with rst_ni pulled low during ACCESS: mem_wren_o drops that cycle, no rvalid; after release, the state is IDLE and r0 wins the first tie.
